// File: rtl/mem_rmw_ctrl.sv
// mem_rmw_ctrl: core-side load/store front end for a synchronous single-port RAM
// with a 1-cycle read latency. Word stores go straight to memory. A sub-word store
// is a read-modify-write: it reads in the accept cycle and writes the merged word
// in the following RMW_WR cycle. Loads read in the accept cycle, and the selected,
// extended lane is returned the cycle after.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   req_valid/_write/_addr/_wdata/_maskMode/_unsigned
//                       core request (maskMode: 0 byte, 1 half, 2/3 word)
//   req_ready           request can be accepted this cycle
//   busy                sub-word store is occupying the memory port
//   rdata, rdata_valid  load result and its strobe (rdata holds between loads)
//   misalign            one-cycle pulse after a rejected misaligned request
//   mem_addr/_rd_en/_wr_en/_wdata, mem_rdata
//                       RAM port (word-aligned address)
module mem_rmw_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_maskMode,
  input  logic        req_unsigned,
  output logic        req_ready,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DW  = 32;
  localparam int unsigned WAW = 30;  // word-address width
  localparam int unsigned HW  = 16;  // widest sub-word lane

  localparam logic [1:0] MODE_BYTE = 2'd0;
  localparam logic [1:0] MODE_HALF = 2'd1;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WAW-1:0]   waddr_q, waddr_d;
  logic [1:0]       off_q, off_d;
  logic [1:0]       mode_q, mode_d;
  logic [HW-1:0]    wdata_q, wdata_d;  // only the low 16 bits can reach a sub-word lane
  logic             uns_q, uns_d;
  logic             ld_pend_q, ld_pend_d;
  logic             mis_q, mis_d;
  logic [DW-1:0]    rdata_q;

  logic             accept;
  logic             mis_req;
  logic             word_req;
  logic [DW-1:0]    merged;
  logic [DW-1:0]    ld_val;
  logic [7:0]       lane8;
  logic [HW-1:0]    lane16;

  // Request classification; maskMode 3 behaves as word.
  assign word_req = req_maskMode[1];
  assign mis_req  = ((req_maskMode == MODE_HALF) && req_addr[0]) ||
                    (word_req && (req_addr[1:0] != 2'b00));

  // Next-state and memory-port control.
  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    off_d     = off_q;
    mode_d    = mode_q;
    wdata_d   = wdata_q;
    uns_d     = uns_q;
    ld_pend_d = 1'b0;
    mis_d     = 1'b0;
    accept    = 1'b0;
    req_ready = 1'b0;
    busy      = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = {req_addr[31:2], 2'b00};
    mem_wdata = req_wdata;

    case (state_q)
      IDLE: begin
        // Requests are ignored while reset is held.
        req_ready = ~reset;
        accept    = req_valid & ~reset;
        if (accept) begin
          if (mis_req) begin
            mis_d = 1'b1;
          end else begin
            waddr_d = req_addr[31:2];
            off_d   = req_addr[1:0];
            mode_d  = req_maskMode;
            uns_d   = req_unsigned;
            wdata_d = req_wdata[HW-1:0];
            if (req_write && word_req) begin
              mem_wr_en = 1'b1;
            end else begin
              mem_rd_en = 1'b1;
              if (req_write) begin
                state_d = RMW_WR;
              end else begin
                ld_pend_d = 1'b1;
              end
            end
          end
        end
      end
      RMW_WR: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = {waddr_q, 2'b00};
        mem_wdata = merged;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Store merge: replace only the target lane of the word read back from memory.
  always_comb begin
    merged = mem_rdata;
    if (mode_q == MODE_BYTE) begin
      case (off_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  // Load lane selection and extension.
  always_comb begin
    case (off_q)
      2'd0:    lane8 = mem_rdata[7:0];
      2'd1:    lane8 = mem_rdata[15:8];
      2'd2:    lane8 = mem_rdata[23:16];
      default: lane8 = mem_rdata[31:24];
    endcase
    lane16 = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (mode_q)
      MODE_BYTE: ld_val = uns_q ? {24'd0, lane8} : {{24{lane8[7]}}, lane8};
      MODE_HALF: ld_val = uns_q ? {16'd0, lane16} : {{16{lane16[15]}}, lane16};
      default:   ld_val = mem_rdata;
    endcase
  end

  // Read data arrives the cycle after the read strobe, so the result is presented
  // straight from mem_rdata in that cycle and held in rdata_q afterwards.
  assign rdata       = ld_pend_q ? ld_val : rdata_q;
  assign rdata_valid = ld_pend_q;
  assign misalign    = mis_q;

  // State and latched request fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      waddr_q   <= '0;
      off_q     <= '0;
      mode_q    <= '0;
      wdata_q   <= '0;
      uns_q     <= 1'b0;
      ld_pend_q <= 1'b0;
      mis_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      off_q     <= off_d;
      mode_q    <= mode_d;
      wdata_q   <= wdata_d;
      uns_q     <= uns_d;
      ld_pend_q <= ld_pend_d;
      mis_q     <= mis_d;
      rdata_q   <= rdata;
    end
  end

endmodule

// File: doc/mem_rmw_ctrl.md
MEM_RMW_CTRL -- requirements
Module: mem_rmw_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have ports req_valid 1, req_write 1, req_addr 32, req_wdata 32, req_maskMode 2 (0 byte, 1 half, 2 word), req_unsigned 1, all inputs, forming the core-side request sampled when req_valid=1.
REQ-004 SHALL have port req_ready  output  1  high when a request is accepted this cycle.
REQ-005 SHALL have port busy  output  1  high while a sub-word store occupies the memory port; the core stalls PC/IF_ID/ID_EX and flushes EX_MEM on it.
REQ-006 SHALL have ports rdata  output  32  load result, and rdata_valid  output  1  load result strobe.
REQ-007 SHALL have port misalign  output  1  one-cycle pulse for a rejected misaligned request.
REQ-008 SHALL have ports mem_addr 32 out (word-aligned, [1:0]=0), mem_rd_en 1 out, mem_wr_en 1 out, mem_wdata 32 out, mem_rdata 32 in, to a synchronous single-port RAM with 1-cycle read latency.

Function
REQ-009 SHALL implement states IDLE and RMW_WR, with state register reset to IDLE.
REQ-010 SHALL assert req_ready=1 in IDLE and 0 in RMW_WR; a request is accepted only when req_valid & req_ready.
REQ-011 SHALL treat an accepted request as misaligned when maskMode=1 with addr[0]=1, or maskMode=2 with addr[1:0]!=0; it then pulses misalign next cycle, issues no mem_rd_en/mem_wr_en, and stays in IDLE.
REQ-012 SHALL treat maskMode=3 as word.
REQ-013 SHALL perform an aligned word store by driving, in the accept cycle, mem_wr_en=1, mem_addr={addr[31:2],2'b00}, mem_wdata=req_wdata, staying in IDLE with busy=0.
REQ-014 SHALL start a sub-word store in the accept cycle with mem_rd_en=1 at the word address, latching addr[1:0], maskMode and wdata, then moving to RMW_WR.
REQ-015 SHALL, in RMW_WR, drive busy=1 and mem_wr_en=1 to the latched address with mem_wdata = mem_rdata having only the target lane replaced (byte lane addr[1:0]*8 from wdata[7:0]; half lane addr[1]*16 from wdata[15:0]), then return to IDLE.
REQ-016 SHALL keep busy combinational on state (1 only in RMW_WR), so a sub-word store costs exactly 2 cycles and word stores and loads cost 1.
REQ-017 SHALL perform a load by driving mem_rd_en=1 at the word address in the accept cycle, latching addr[1:0], maskMode and unsigned.
REQ-018 SHALL, in the cycle after load accept, assert rdata_valid=1 with rdata = selected lane, zero-extended if unsigned, else sign-extended from bit 7 or 15; word loads pass mem_rdata unchanged.
REQ-019 SHALL accept back-to-back loads each cycle, one rdata_valid per load in order.
REQ-020 SHALL let a load accepted the cycle after a sub-word store acceptance wait (req_ready=0 in RMW_WR); no request is dropped or reordered.
REQ-021 SHALL hold rdata at its last value when rdata_valid=0.
REQ-022 SHALL never assert mem_rd_en and mem_wr_en in the same cycle.

Reset
REQ-023 SHALL on reset assertion immediately force state=IDLE, busy=0, rdata_valid=0, misalign=0, rdata=0, mem_rd_en=0, mem_wr_en=0, and clear all latched request fields.
REQ-024 SHALL abandon a sub-word store when reset arrives in RMW_WR: no write is issued and memory keeps its pre-store contents.
REQ-025 SHALL ignore req_valid while reset is high; the first acceptance is possible on the first rising edge after deassertion.

Verification
REQ-026 Word store addr 0x100, wdata 0xDEADBEEF -> same cycle mem_wr_en=1, mem_addr=0x100, busy never 1.
REQ-027 Mem[0x100]=0x11223344; byte store addr 0x102, wdata 0xAB -> cycle0 mem_rd_en, cycle1 busy=1, mem_wr_en, mem_wdata=0x11AB3344.
REQ-028 Mem[0x200]=0x8000F0FF; half load signed 0x202 -> rdata=0xFFFF8000; byte load unsigned 0x200 -> rdata=0x000000FF, each one cycle after accept.
REQ-029 Half store addr 0x101 -> misalign pulse, no memory strobes; word load addr 0x102 -> misalign pulse.
REQ-030 Half store 0x300 then load 0x304 on next cycle -> req_ready=0 during RMW_WR, load accepted one cycle later, rdata_valid exactly once.
REQ-031 Reset asserted during RMW_WR -> busy and mem_wr_en drop immediately, memory word unchanged.
